// File: rtl/game_tick_sched_if.sv
// Bundles the game-timing controls and the timing outputs shared with the
// input logic, mole generator, score and display blocks.
interface game_tick_sched_if;
   logic       start;
   logic       pause;
   logic [1:0] level;
   logic       scan_tick;
   logic       sec_tick;
   logic       mole_tick;
   logic [6:0] time_left;
   logic [1:0] state;
   logic       game_over;

   // Master drives the requests and level select, then observes the timing outputs.
   modport master (
      output start, pause, level,
      input  scan_tick, sec_tick, mole_tick, time_left, state, game_over
   );

   // Slave is the scheduler itself.
   modport slave (
      input  start, pause, level,
      output scan_tick, sec_tick, mole_tick, time_left, state, game_over
   );
endinterface

// File: rtl/game_tick_sched.sv
// Central game timing controller for whack-a-mole. A free-running prescaler
// gives the base tick. A run/pause/over machine gates the seconds counter,
// the level-dependent mole counter and the remaining-time count.
module game_tick_sched #(
   parameter int PRE_DIV  = 50000,
   parameter int TPS      = 1000,
   parameter int GAME_SEC = 60,
   parameter int MOLE_P0  = 1500,
   parameter int MOLE_P1  = 1000,
   parameter int MOLE_P2  = 700,
   parameter int MOLE_P3  = 400
) (
   input  logic              clk,
   input  logic              rst,
   game_tick_sched_if.slave  bus
);

   localparam int MOLE_MAX01 = (MOLE_P0 > MOLE_P1) ? MOLE_P0 : MOLE_P1;
   localparam int MOLE_MAX23 = (MOLE_P2 > MOLE_P3) ? MOLE_P2 : MOLE_P3;
   localparam int MOLE_MAX   = (MOLE_MAX01 > MOLE_MAX23) ? MOLE_MAX01 : MOLE_MAX23;

   localparam int PRE_W  = $clog2(PRE_DIV);
   localparam int MS_W   = $clog2(TPS);
   localparam int MOLE_W = $clog2(MOLE_MAX);

   localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(PRE_DIV - 1);
   localparam logic [MS_W-1:0]   MS_LAST    = MS_W'(TPS - 1);
   localparam logic [MOLE_W-1:0] MOLE_LAST0 = MOLE_W'(MOLE_P0 - 1);
   localparam logic [MOLE_W-1:0] MOLE_LAST1 = MOLE_W'(MOLE_P1 - 1);
   localparam logic [MOLE_W-1:0] MOLE_LAST2 = MOLE_W'(MOLE_P2 - 1);
   localparam logic [MOLE_W-1:0] MOLE_LAST3 = MOLE_W'(MOLE_P3 - 1);
   localparam logic [6:0]        ROUND_LEN  = 7'(GAME_SEC);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      OVER  = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic [PRE_W-1:0]    preCnt_q, preCnt_d;
   logic [MS_W-1:0]     msCnt_q, msCnt_d;
   logic [MOLE_W-1:0]   moleCnt_q, moleCnt_d;
   logic [6:0]          timeLeft_q, timeLeft_d;
   logic [1:0]          level_q, level_d;
   logic                scanTick_q, scanTick_d;
   logic                secTick_q, secTick_d;
   logic                moleTick_q, moleTick_d;
   logic                gameOver_q, gameOver_d;

   logic                base;
   logic                advance;
   logic                load;
   logic                msWrap;
   logic                moleWrap;
   logic [MOLE_W-1:0]   moleLast;

   // A pause request on a base edge wins over counting; start is only a load outside RUN.
   assign base     = (preCnt_q == PRE_LAST);
   assign advance  = (state_q == RUN) && !bus.pause && base;
   assign load     = bus.start && (state_q != RUN);
   assign msWrap   = (msCnt_q == MS_LAST);
   assign moleWrap = (moleCnt_q == moleLast);

   // Pick the terminal mole count for the level latched at the last period boundary.
   always_comb begin
      moleLast = MOLE_LAST0;
      case (level_q)
         2'd0: moleLast = MOLE_LAST0;
         2'd1: moleLast = MOLE_LAST1;
         2'd2: moleLast = MOLE_LAST2;
         2'd3: moleLast = MOLE_LAST3;
         default: moleLast = MOLE_LAST0;
      endcase
   end

   // Game state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next game state: the round ends on the edge where the last second expires.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (bus.start) state_d = RUN;
         RUN: begin
            if (bus.pause)                                     state_d = PAUSE;
            else if (advance && msWrap && timeLeft_q == 7'd1)  state_d = OVER;
         end
         PAUSE: if (bus.start || bus.pause) state_d = RUN;
         OVER:  if (bus.start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the counters and registered outputs.
   always_comb begin
      preCnt_d   = base ? '0 : preCnt_q + PRE_W'(1);
      msCnt_d    = msCnt_q;
      moleCnt_d  = moleCnt_q;
      timeLeft_d = timeLeft_q;
      level_d    = level_q;
      scanTick_d = base;
      secTick_d  = advance && msWrap;
      moleTick_d = advance && moleWrap;
      gameOver_d = (state_d == OVER);
      if (load) begin
         msCnt_d    = '0;
         moleCnt_d  = '0;
         timeLeft_d = ROUND_LEN;
         level_d    = bus.level;
      end else if (advance) begin
         msCnt_d   = msWrap ? '0 : msCnt_q + MS_W'(1);
         moleCnt_d = moleWrap ? '0 : moleCnt_q + MOLE_W'(1);
         if (msWrap)   timeLeft_d = timeLeft_q - 7'd1;
         if (moleWrap) level_d    = bus.level;
      end
   end

   // Counter and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         preCnt_q   <= '0;
         msCnt_q    <= '0;
         moleCnt_q  <= '0;
         timeLeft_q <= ROUND_LEN;
         level_q    <= 2'd0;
         scanTick_q <= 1'b0;
         secTick_q  <= 1'b0;
         moleTick_q <= 1'b0;
         gameOver_q <= 1'b0;
      end else begin
         preCnt_q   <= preCnt_d;
         msCnt_q    <= msCnt_d;
         moleCnt_q  <= moleCnt_d;
         timeLeft_q <= timeLeft_d;
         level_q    <= level_d;
         scanTick_q <= scanTick_d;
         secTick_q  <= secTick_d;
         moleTick_q <= moleTick_d;
         gameOver_q <= gameOver_d;
      end
   end

   assign bus.scan_tick = scanTick_q;
   assign bus.sec_tick  = secTick_q;
   assign bus.mole_tick = moleTick_q;
   assign bus.time_left = timeLeft_q;
   assign bus.state     = state_q;
   assign bus.game_over = gameOver_q;

endmodule

// File: tb/tb_game_tick_sched.sv
// Bench for the game tick scheduler: directed scenarios plus random requests,
// every cycle compared against a model that counts elapsed game ticks.
module tb_game_tick_sched;

   localparam int PRE_DIV  = 4;
   localparam int TPS      = 5;
   localparam int GAME_SEC = 3;
   localparam int MOLE_P0  = 6;
   localparam int MOLE_P1  = 4;
   localparam int MOLE_P2  = 3;
   localparam int MOLE_P3  = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int vectorsApplied = 0;
   int miscompares    = 0;

   int cyc;
   int mState;
   int runTicks;
   int moleTicks;
   int mLevel;
   bit expScan;
   bit expSec;
   bit expMole;

   game_tick_sched_if bus();

   game_tick_sched #(
      .PRE_DIV(PRE_DIV), .TPS(TPS), .GAME_SEC(GAME_SEC),
      .MOLE_P0(MOLE_P0), .MOLE_P1(MOLE_P1), .MOLE_P2(MOLE_P2), .MOLE_P3(MOLE_P3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   function automatic int molePeriod(input int lv);
      case (lv)
         0: return MOLE_P0;
         1: return MOLE_P1;
         2: return MOLE_P2;
         default: return MOLE_P3;
      endcase
   endfunction

   // Single comparison point: counts the vector and reports any miscompare.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorsApplied++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      cyc = 0; mState = 0; runTicks = 0; moleTicks = 0; mLevel = 0;
      expScan = 0; expSec = 0; expMole = 0;
   endtask

   task automatic modelLoad(input int lv);
      mState = 1; runTicks = 0; moleTicks = 0; mLevel = lv;
   endtask

   // One clock edge of the game rules, in terms of elapsed base ticks.
   task automatic modelStep(input bit s, input bit p, input int lv);
      bit base;
      base    = (cyc % PRE_DIV) == (PRE_DIV - 1);
      expScan = base;
      expSec  = 0;
      expMole = 0;
      case (mState)
         0: if (s) modelLoad(lv);
         1: begin
            if (p) mState = 2;
            else if (base) begin
               runTicks++;
               moleTicks++;
               if (runTicks % TPS == 0) expSec = 1;
               if (moleTicks == molePeriod(mLevel)) begin
                  moleTicks = 0;
                  expMole   = 1;
                  mLevel    = lv;
               end
               if (runTicks == GAME_SEC * TPS) mState = 3;
            end
         end
         2: begin
            if (s)      modelLoad(lv);
            else if (p) mState = 1;
         end
         default: if (s) modelLoad(lv);
      endcase
      cyc++;
   endtask

   task automatic checkAll();
      checkOutput("scan_tick", 32'(bus.scan_tick), 32'(expScan));
      checkOutput("sec_tick",  32'(bus.sec_tick),  32'(expSec));
      checkOutput("mole_tick", 32'(bus.mole_tick), 32'(expMole));
      checkOutput("time_left", 32'(bus.time_left), 32'(GAME_SEC - runTicks / TPS));
      checkOutput("state",     32'(bus.state),     32'(mState));
      checkOutput("game_over", 32'(bus.game_over), 32'(mState == 3));
   endtask

   // Drive one cycle of requests, step the model on the edge and compare just after it.
   task automatic applyStimulus(input bit s, input bit p, input logic [1:0] lv);
      bus.start = s;
      bus.pause = p;
      bus.level = lv;
      @(posedge clk);
      modelStep(s, p, int'(lv));
      #1;
      checkAll();
      bus.start = 1'b0;
      bus.pause = 1'b0;
   endtask

   task automatic idleCycles(input int n, input logic [1:0] lv);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, lv);
   endtask

   // Asynchronous reset: outputs must drop before any clock edge arrives.
   task automatic pulseReset();
      rst = 1'b1;
      #1;
      checkOutput("rst_scan",      32'(bus.scan_tick), 32'd0);
      checkOutput("rst_sec",       32'(bus.sec_tick),  32'd0);
      checkOutput("rst_mole",      32'(bus.mole_tick), 32'd0);
      checkOutput("rst_time_left", 32'(bus.time_left), 32'(GAME_SEC));
      checkOutput("rst_state",     32'(bus.state),     32'd0);
      checkOutput("rst_game_over", 32'(bus.game_over), 32'd0);
      modelReset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [1:0] lv;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.level = 2'd0;
      #2;
      pulseReset();

      // Idle after reset: scan ticks only.
      idleCycles(20, 2'd0);

      // Full round at level 0 into OVER, then linger.
      applyStimulus(1'b1, 1'b0, 2'd0);
      idleCycles(75, 2'd0);

      // Level 3 with a mid-period switch to level 1.
      applyStimulus(1'b1, 1'b0, 2'd3);
      idleCycles(3, 2'd3);
      idleCycles(50, 2'd1);

      // Pause after 7 clocks, hold, resume.
      applyStimulus(1'b1, 1'b0, 2'd0);
      idleCycles(6, 2'd0);
      applyStimulus(1'b0, 1'b1, 2'd0);
      idleCycles(50, 2'd0);
      applyStimulus(1'b0, 1'b1, 2'd0);
      idleCycles(40, 2'd0);

      // Start and pause together while paused: reload wins.
      applyStimulus(1'b1, 1'b0, 2'd2);
      idleCycles(9, 2'd2);
      applyStimulus(1'b0, 1'b1, 2'd2);
      idleCycles(10, 2'd2);
      applyStimulus(1'b1, 1'b1, 2'd1);
      idleCycles(30, 2'd1);

      // Reset mid-round with one second left, then a full fresh round.
      applyStimulus(1'b1, 1'b0, 2'd0);
      for (int i = 0; i < 100 && runTicks < 2 * TPS + 2; i++) applyStimulus(1'b0, 1'b0, 2'd0);
      checkOutput("one_sec_left", 32'(bus.time_left), 32'd1);
      #2;
      pulseReset();
      applyStimulus(1'b1, 1'b0, 2'd0);
      idleCycles(70, 2'd0);

      // Random requests, level changes and occasional resets.
      lv = 2'd0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 19) == 0) lv = 2'($urandom_range(0, 3));
         applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0, lv);
         if ($urandom_range(0, 499) == 0) begin
            #2;
            pulseReset();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
